gpio_debounce_events: RTL and testbench

Input-conditioning stage directly upstream of the team_05 project core. Takes raw button/switch lines from gpio_in and, per channel:
- synchronizes them to clk;
- debounces them;
- emits clean levels plus one-cycle edge pulses.
Edges are also queued as events in a small FIFO with a valid/ready interface, so the core can consume presses without missing any.

---
 rtl/gpio_cond_pkg.sv | 21 ++
 rtl/gpio_evt_fifo.sv | 61 ++++++
 rtl/gpio_debounce_events.sv | 164 ++++++++++++++++
 tb/tb_gpio_debounce_events.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cond_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_cond_pkg : shared types and default constants for GPIO cond.    |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package gpio_cond_pkg;

  localparam int c_nch_def        = 8;
  localparam int c_db_cycles_def  = 1000;
  localparam int c_fifo_depth_def = 4;

  // Code field sized for the 16-channel maximum so one event type serves every build
  localparam int c_evt_code_w     = 4;

  typedef struct packed {
    logic [c_evt_code_w-1:0] code;
    logic                    rise;
  } gpio_evt_t;

endpackage
`default_nettype wire

// File: rtl/gpio_evt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_evt_fifo : show-ahead FIFO of gpio_evt_t with push/full,        |
// |                 pop/valid and occupancy count.   Revision: 1.0       |
// +----------------------------------------------------------------------+
module gpio_evt_fifo
  import gpio_cond_pkg::*;
#(
  parameter int DEPTH = c_fifo_depth_def,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  gpio_evt_t        din,
  output logic             full,
  input  logic             pop,
  output gpio_evt_t        dout,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int c_ptr_w = $clog2(DEPTH);

  gpio_evt_t          r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr;
  logic [c_ptr_w-1:0] r_rd;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign valid  = (r_count != '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd];
  // A full FIFO refuses a push even when a pop frees a slot the same cycle
  assign w_push = push && !full;
  assign w_pop  = pop && valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/gpio_debounce_events.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_debounce_events : sync + debounce + edge pulses + event FIFO.   |
// | Option DEBOUNCE_BYPASS_EN removes the counters.   Revision: 1.0      |
// +----------------------------------------------------------------------+
module gpio_debounce_events
  import gpio_cond_pkg::*;
#(
  parameter int NCH        = c_nch_def,
  parameter int DB_CYCLES  = c_db_cycles_def,
  parameter int FIFO_DEPTH = c_fifo_depth_def,
  parameter int CODE_W     = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    raw_in,
  output logic [NCH-1:0]    level_out,
  output logic [NCH-1:0]    rise_pulse,
  output logic [NCH-1:0]    fall_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_rise,
  output logic              evt_overflow,
  input  logic              overflow_clr
);

  localparam int c_fcnt_w = $clog2(FIFO_DEPTH) + 1;

  logic [NCH-1:0]      r_sync1, r_sync2, r_level, r_rise, r_fall;
  logic [NCH-1:0]      r_pend, r_pdir;
  logic                r_ovf;
  logic [NCH-1:0]      w_edge, w_grant, w_take, w_lost;
  logic [CODE_W-1:0]   w_sel;
  logic                w_push, w_full, w_fvalid;
  logic [c_fcnt_w-1:0] w_count;
  gpio_evt_t           w_din, w_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_BYPASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      if (en) begin
        r_level <= r_sync2;
        r_rise  <= r_sync2 & ~r_level;
        r_fall  <= ~r_sync2 & r_level;
      end
    end
  end
`else
  localparam int c_cnt_w = $clog2(DB_CYCLES);

  logic [c_cnt_w-1:0] r_cnt [NCH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (!en || (r_sync2[i] == r_level[i])) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_cnt_w'(DB_CYCLES - 1)) begin
          r_cnt[i]   <= '0;
          r_level[i] <= r_sync2[i];
          r_rise[i]  <= r_sync2[i];
          r_fall[i]  <= ~r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end
`endif

  // Lowest pending channel wins the single push slot
  always_comb begin
    w_grant = '0;
    w_sel   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_grant    = '0;
        w_grant[i] = 1'b1;
        w_sel      = CODE_W'(i);
      end
    end
  end

  assign w_push = (|w_grant) && !w_full;
  assign w_take = w_grant & {NCH{w_push}};
  assign w_edge = r_rise | r_fall;
  // An edge lands on an occupied slot that is not being drained this cycle
  assign w_lost = w_edge & r_pend & ~w_take;

  always_comb begin
    w_din      = '0;
    w_din.code = c_evt_code_w'(w_sel);
    w_din.rise = |(r_pdir & w_grant);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_pdir <= '0;
      r_ovf  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_edge[i]) begin
          r_pend[i] <= 1'b1;
          r_pdir[i] <= r_rise[i];
        end else if (w_take[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
      if (|w_lost)           r_ovf <= 1'b1;
      else if (overflow_clr) r_ovf <= 1'b0;
    end
  end

  gpio_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (c_fcnt_w)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_din),
    .full  (w_full),
    .pop   (evt_ready && w_fvalid),
    .dout  (w_dout),
    .valid (w_fvalid),
    .count (w_count)
  );

  assign level_out    = r_level;
  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;
  assign evt_valid    = (w_count != '0);
  assign evt_code     = w_dout.code[CODE_W-1:0];
  assign evt_rise     = w_dout.rise;
  assign evt_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_gpio_debounce_events.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gpio_debounce_events : directed + random bench with event model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gpio_debounce_events;

  localparam int NCH   = 4;
  localparam int DB    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 2;

  logic           clk = 1'b0;
  logic           rst, en, evt_ready, overflow_clr;
  logic [NCH-1:0] raw_in, level_out, rise_pulse, fall_pulse;
  logic           evt_valid, evt_rise, evt_overflow;
  logic [CW-1:0]  evt_code;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpio_debounce_events #(
    .NCH        (NCH),
    .DB_CYCLES  (DB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .raw_in       (raw_in),
    .level_out    (level_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_rise     (evt_rise),
    .evt_overflow (evt_overflow),
    .overflow_clr (overflow_clr)
  );

  // Reference: raw delayed two cycles, a level flips after DB straight
  // enabled cycles of disagreement; events kept as code*2+rise in a queue.
  bit [NCH-1:0] m_s1, m_s2, m_level, m_rise, m_fall, m_pend, m_pdir;
  int           m_run [NCH];
  int           m_q [$];
  bit           m_ovf;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
    m_pend = '0; m_pdir = '0; m_ovf = 1'b0;
    for (int i = 0; i < NCH; i++) m_run[i] = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    int sz, sel;
    bit lost;
    sz = m_q.size(); sel = -1; lost = 1'b0;
    if (sz < DEPTH)
      for (int i = 0; i < NCH; i++) if (m_pend[i] && sel < 0) sel = i;
    if (sz != 0 && evt_ready) void'(m_q.pop_front());
    if (sel >= 0) begin
      m_q.push_back(sel * 2 + int'(m_pdir[sel]));
      m_pend[sel] = 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (m_rise[i] || m_fall[i]) begin
        if (m_pend[i]) lost = 1'b1;
        m_pend[i] = 1'b1;
        m_pdir[i] = m_rise[i];
      end
    end
    if (lost) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (en && (m_s2[i] != m_level[i])) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] >= DB) begin
          m_level[i] = m_s2[i];
          m_rise[i]  = m_s2[i];
          m_fall[i]  = !m_s2[i];
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw_in;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("level_out", 32'(level_out), 32'(m_level));
    chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
    chk("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
    chk("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
    if (m_q.size() != 0) begin
      chk("evt_code", 32'(evt_code), 32'(m_q[0] >> 1));
      chk("evt_rise", 32'(evt_rise), 32'(m_q[0] & 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int got [$];
    int exp3 [3];
    int exp4 [5];
    exp3 = '{0, 2, 3};
    exp4 = '{0, 2, 4, 6, 0};

    rst = 1'b1; en = 1'b1; raw_in = '0; evt_ready = 1'b0; overflow_clr = 1'b0;
    model_reset();
    steps(2);
    chk("reset_level", 32'(level_out), 32'h0);
    chk("reset_valid", 32'(evt_valid), 32'h0);
    rst = 1'b0;
    steps(2);

    // Single rise on channel 1: level after exactly 2+DB edges
    raw_in[1] = 1'b1;
    steps(5);
    chk("t1_level_early", 32'(level_out[1]), 32'h0);
    step();
    chk("t1_level", 32'(level_out[1]), 32'h1);
    chk("t1_rise_pulse", 32'(rise_pulse[1]), 32'h1);
    step();
    chk("t1_pulse_1cyc", 32'(rise_pulse[1]), 32'h0);
    step();
    chk("t1_valid", 32'(evt_valid), 32'h1);
    chk("t1_code", 32'(evt_code), 32'h1);
    chk("t1_rise", 32'(evt_rise), 32'h1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;

    // Short glitches on channel 0 never propagate
    for (int k = 0; k < 15; k++) begin
      raw_in[0] = (k % 3 == 0);
      step();
      chk("t2_level0", 32'(level_out[0]), 32'h0);
      chk("t2_valid", 32'(evt_valid), 32'h0);
    end
    raw_in[0] = 1'b0;
    steps(3);

    // Simultaneous rises drain in index order
    evt_ready = 1'b1;
    raw_in = raw_in | 4'b1101;
    got.delete();
    for (int k = 0; k < 20 && got.size() < 3; k++) begin
      if (evt_valid && evt_ready) got.push_back(int'(evt_code));
      step();
    end
    chk("t3_count", 32'(got.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk("t3_order", (k < got.size()) ? 32'(got[k]) : 32'hFF, 32'(exp3[k]));
    chk("t3_ovf", 32'(evt_overflow), 32'h0);

    // Fill FIFO with four falls, hold a fifth, overwrite it to force overflow
    evt_ready = 1'b0;
    raw_in = 4'b0000;
    steps(12);
    chk("t4_valid", 32'(evt_valid), 32'h1);
    raw_in[0] = 1'b1;
    steps(10);
    chk("t4_no_ovf", 32'(evt_overflow), 32'h0);
    raw_in[0] = 1'b0;
    steps(10);
    chk("t4_ovf", 32'(evt_overflow), 32'h1);
    evt_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 20 && got.size() < 5; k++) begin
      if (evt_valid && evt_ready) got.push_back(int'(evt_code) * 2 + int'(evt_rise));
      step();
    end
    chk("t4_count", 32'(got.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      chk("t4_event", (k < got.size()) ? 32'(got[k]) : 32'hFF, 32'(exp4[k]));
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("t4_ovf_clr", 32'(evt_overflow), 32'h0);

    // Disabled block holds its levels
    evt_ready = 1'b0;
    en = 1'b0;
    raw_in[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t5_hold", 32'(level_out[3]), 32'h0);
    end
    en = 1'b1;
    steps(3);
    chk("t5_early", 32'(level_out[3]), 32'h0);
    step();
    chk("t5_level", 32'(level_out[3]), 32'h1);

    // Reset with three queued events and a counter mid-count
    raw_in = 4'b1011;
    steps(10);
    raw_in[3] = 1'b0;
    steps(3);
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_valid", 32'(evt_valid), 32'h0);
    chk("t6_level", 32'(level_out), 32'h0);
    chk("t6_ovf", 32'(evt_overflow), 32'h0);
    @(negedge clk);
    steps(1);
    rst = 1'b0;
    steps(5);
    chk("t6_relearn_early", 32'(level_out), 32'h0);
    step();
    chk("t6_relearn", 32'(level_out), 32'h3);

    // Random traffic with bursty consumer stalls
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) raw_in[$urandom_range(0, NCH - 1)] ^= 1'b1;
      en           = ($urandom_range(0, 15) != 0);
      evt_ready    = ((k / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
      overflow_clr = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
